// File: rtl/lsu_pkg.sv
// lsu_pkg: shared ALU/LSU codes, LSU state encoding and access helpers.
package lsu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
  function automatic logic access_err(input logic wen, input logic [2:0] f3, input logic [1:0] off);
    logic legal;
    logic mis;
    legal = wen ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    mis = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    return !legal || mis;
  endfunction
  function automatic logic [3:0] lane_mask(input logic wen, input logic [2:0] f3, input logic [1:0] off);
    return !wen ? 4'b1111 : f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  endfunction
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    return f3[1:0] == 2'b00 ? {4{d[7:0]}} : f3[1:0] == 2'b01 ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane extraction and sign/zero extension of a load word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [31:0] w_sh;
  assign w_sh = i_rdata >> {i_off, 3'b000};
  always_comb begin
    o_data = i_funct3 == F3_B  ? {{24{w_sh[7]}}, w_sh[7:0]} :
             i_funct3 == F3_H  ? {{16{w_sh[15]}}, w_sh[15:0]} :
             i_funct3 == F3_W  ? w_sh :
             i_funct3 == F3_BU ? {24'd0, w_sh[7:0]} :
             i_funct3 == F3_HU ? {16'd0, w_sh[15:0]} : 32'd0;
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding RV32 load/store unit with request/response memory port.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);
  lsu_state_e  r_state, w_next;
  logic        r_wen, r_err;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [3:0]  r_mask;
  logic [31:0] r_maddr, r_mwdata, r_rdata, w_load;
  logic        w_acc, w_err;
  assign w_acc = in_valid && in_ready;
  assign w_err = access_err(in_wen, in_funct3, in_addr[1:0]);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_acc ? (w_err ? S_DONE : S_REQ) : S_IDLE;
      S_REQ:   w_next = mem_req_ready ? S_WAIT : S_REQ;
      S_WAIT:  w_next = mem_rsp_valid ? S_DONE : S_WAIT;
      S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // Memory-side fields are only refreshed for legal accesses so an error never disturbs the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_err    <= 1'b0;
      r_f3     <= 3'd0;
      r_off    <= 2'd0;
      r_mask   <= 4'd0;
      r_maddr  <= 32'd0;
      r_mwdata <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      if (w_acc) begin
        r_f3    <= in_funct3;
        r_off   <= in_addr[1:0];
        r_err   <= w_err;
        r_rdata <= 32'd0;
        if (!w_err) begin
          r_wen    <= in_wen;
          r_maddr  <= {in_addr[31:2], 2'b00};
          r_mask   <= lane_mask(in_wen, in_funct3, in_addr[1:0]);
          r_mwdata <= lane_data(in_funct3, in_wdata);
        end
      end
      if (r_state == S_WAIT && mem_rsp_valid) r_rdata <= r_wen ? 32'd0 : w_load;
    end
  end
  lsu_align u_align (
    .i_rdata (mem_rdata),
    .i_off   (r_off),
    .i_funct3(r_f3),
    .o_data  (w_load)
  );
  assign in_ready      = r_state == S_IDLE;
  assign mem_req_valid = r_state == S_REQ;
  assign mem_addr      = r_maddr;
  assign mem_wen       = r_wen;
  assign mem_wmask     = r_mask;
  assign mem_wdata     = r_mwdata;
  assign out_valid     = r_state == S_DONE;
  assign out_rdata     = r_rdata;
  assign out_err       = r_err;
endmodule
